// File: rtl/xtal_startup_controller_if.sv
// xtal_startup_controller_if: control and status bundle between the controller and its oscillator/host
interface xtal_startup_controller_if;
  logic       enable;
  logic       xtal_sense;
  logic       xtal_enable;
  logic [2:0] bias;
  logic       clock_good;
  logic       clock_fail;
  logic [2:0] state;
  modport master (output enable, xtal_sense, input xtal_enable, bias, clock_good, clock_fail, state);
  modport slave  (input enable, xtal_sense, output xtal_enable, bias, clock_good, clock_fail, state);
endinterface

// File: rtl/xtal_startup_controller.sv
// xtal_startup_controller: enables a crystal, verifies its edge rate per window, retries with
// stronger bias and gives up after a bounded number of failed attempts.
module xtal_startup_controller #(
  parameter int         STARTUP_CYCLES   = 1024,
  parameter int         EDGE_WINDOW      = 64,
  parameter int         MIN_EDGES        = 8,
  parameter int         MAX_RETRIES      = 3,
  parameter int         RETRY_OFF_CYCLES = 16,
  parameter logic [2:0] BIAS_INIT        = 3'd3
) (
  input logic clk_i,
  input logic rst_i,
  xtal_startup_controller_if.slave xif
);
  localparam int MAXT = (STARTUP_CYCLES > EDGE_WINDOW)
                      ? ((STARTUP_CYCLES > RETRY_OFF_CYCLES) ? STARTUP_CYCLES : RETRY_OFF_CYCLES)
                      : ((EDGE_WINDOW > RETRY_OFF_CYCLES) ? EDGE_WINDOW : RETRY_OFF_CYCLES);
  localparam int TW = $clog2(MAXT + 1);
  localparam int RW = $clog2(MAX_RETRIES + 1);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STARTUP = 3'd1,
    CHECK   = 3'd2,
    RUNNING = 3'd3,
    RETRY   = 3'd4,
    FAIL    = 3'd5
  } state_e;
  state_e          state_q;
  logic [TW-1:0]   timer_q, timer_d;
  logic [7:0]      edges_q, edges_d;
  logic [RW-1:0]   retry_q, retry_d;
  logic [2:0]      bias_q, bias_d;
  logic [2:0]      sync_q;
  logic            xen_q, good_q, fail_q;
  logic            rise, win_end, start_end, off_end, pass, give_up;
  // sync_q[1] is the synchronized sense, sync_q[2] its previous value
  always_ff @(posedge clk_i)
    if (rst_i) sync_q <= '0;
    else sync_q <= {sync_q[1:0], xif.xtal_sense};
  always_comb begin
    rise      = sync_q[1] & ~sync_q[2];
    edges_d   = (&edges_q) ? edges_q : edges_q + {7'd0, rise};
    timer_d   = timer_q + TW'(1);
    retry_d   = retry_q + RW'(1);
    bias_d    = (&bias_q) ? bias_q : bias_q + 3'd1;
    win_end   = timer_q == TW'(EDGE_WINDOW - 1);
    start_end = timer_q == TW'(STARTUP_CYCLES - 1);
    off_end   = timer_q == TW'(RETRY_OFF_CYCLES - 1);
    pass      = edges_d >= 8'(MIN_EDGES);
    give_up   = retry_d == RW'(MAX_RETRIES);
  end
  // Enable low outranks every transition, including a window that ends this cycle
  always_ff @(posedge clk_i)
    if (rst_i || !xif.enable) begin
      state_q <= IDLE;
      timer_q <= '0;
      edges_q <= '0;
      retry_q <= '0;
      bias_q  <= BIAS_INIT;
      xen_q   <= 1'b0;
      good_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= STARTUP;
          timer_q <= '0;
          xen_q   <= 1'b1;
        end
        STARTUP: begin
          timer_q <= start_end ? '0 : timer_d;
          edges_q <= '0;
          if (start_end) state_q <= CHECK;
        end
        CHECK, RUNNING: begin
          timer_q <= win_end ? '0 : timer_d;
          edges_q <= win_end ? '0 : edges_d;
          if (win_end && pass) begin
            state_q <= RUNNING;
            good_q  <= 1'b1;
            retry_q <= '0;
          end else if (win_end) begin
            state_q <= give_up ? FAIL : RETRY;
            fail_q  <= give_up;
            retry_q <= retry_d;
            bias_q  <= bias_d;
            xen_q   <= 1'b0;
            good_q  <= 1'b0;
          end
        end
        RETRY: begin
          timer_q <= off_end ? '0 : timer_d;
          if (off_end) begin
            state_q <= STARTUP;
            xen_q   <= 1'b1;
          end
        end
        FAIL: state_q <= FAIL;
        default: state_q <= IDLE;
      endcase
    end
  assign xif.state       = state_q;
  assign xif.xtal_enable = xen_q;
  assign xif.bias        = bias_q;
  assign xif.clock_good  = good_q;
  assign xif.clock_fail  = fail_q;
endmodule
